// File: rtl/updn_mod_counter.sv
// Up/down modulo-(MAX+1) counter with one-shot halt and terminal-count pulse.
// Optional parallel load: define UPDN_CNT_LOAD_EN to add load/load_val ports.
module updn_mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             oneshot,
`ifdef UPDN_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic             tc_r, tc_s;
  logic             done_r, done_s;
  logic             term_s;
  logic             load_s;
  logic [WIDTH-1:0] load_val_s;

  // Out-of-range load values clamp to the terminal so the count stays in 0..MAX.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    if (v > MAX_V) begin
      sat_load = MAX_V;
    end else begin
      sat_load = v;
    end
  endfunction

`ifdef UPDN_CNT_LOAD_EN
  assign load_s     = load;
  assign load_val_s = load_val;
`else
  assign load_s     = 1'b0;
  assign load_val_s = ZERO_V;
`endif

  // Next-state, next-count and flag logic; load overrides everything.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    tc_s    = 1'b0;
    done_s  = done_r;
    term_s  = up_dn ? (count_r == MAX_V) : (count_r == ZERO_V);
    if (load_s) begin
      state_s = RUN;
      count_s = sat_load(load_val_s);
      tc_s    = 1'b0;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          done_s = 1'b0;
          if (en) begin
            if (!term_s) begin
              count_s = up_dn ? (count_r + ONE_V) : (count_r - ONE_V);
            end else if (!oneshot) begin
              count_s = up_dn ? ZERO_V : MAX_V;
              tc_s    = 1'b1;
            end else begin
              tc_s    = 1'b1;
              state_s = HALT;
              done_s  = 1'b1;
            end
          end else begin
            count_s = count_r;
          end
        end
        HALT: begin
          if (!oneshot) begin
            state_s = RUN;
            done_s  = 1'b0;
          end else begin
            state_s = HALT;
            done_s  = 1'b1;
          end
        end
        default: begin
          state_s = RUN;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset parks at the top of the range.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RUN;
      count_r <= MAX_V;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      tc_r    <= tc_s;
      done_r  <= done_s;
    end
  end

  assign count_out = count_r;
  assign tc        = tc_r;
  assign done      = done_r;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Scoreboard bench for updn_mod_counter: a WIDTH=4/MAX=9 instance under directed
// and random stimulus, plus a WIDTH=3 free-running legacy down counter.
module tb_updn_mod_counter;

  localparam int MX = 9;
`ifdef UPDN_CNT_LOAD_EN
  localparam bit HAS_LOAD = 1'b1;
`else
  localparam bit HAS_LOAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       oneshot = 1'b0;
  logic [3:0] count_out;
  logic       tc, done;
  logic [2:0] count3;
  logic       tc3, done3;
`ifdef UPDN_CNT_LOAD_EN
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int tc;
    int done;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];

  int m_cnt = MX, m_tc = 0, m_done = 0;
  int m3 = 7, m3_tc = 0;

  updn_mod_counter #(.WIDTH(4), .MAX(MX)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .oneshot(oneshot),
`ifdef UPDN_CNT_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .count_out(count_out), .tc(tc), .done(done)
  );

  updn_mod_counter #(.WIDTH(3)) dut3 (
    .clk(clk), .rstn(rstn), .en(1'b1), .up_dn(1'b0), .oneshot(1'b0),
`ifdef UPDN_CNT_LOAD_EN
    .load(1'b0), .load_val(3'd0),
`endif
    .count_out(count3), .tc(tc3), .done(done3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model predicts the state after the next edge.
  task automatic step(input logic e, input logic u, input logic os,
                      input logic ld, input logic [3:0] lv);
    exp_t x, x3;
    bit   term;
    @(negedge clk);
    rstn    = 1'b1;
    en      = e;
    up_dn   = u;
    oneshot = os;
`ifdef UPDN_CNT_LOAD_EN
    load     = ld;
    load_val = lv;
`endif
    term = u ? (m_cnt == MX) : (m_cnt == 0);
    if (HAS_LOAD && ld) begin
      m_cnt  = (lv > MX) ? MX : int'(lv);
      m_tc   = 0;
      m_done = 0;
    end else if (m_done == 1) begin
      m_tc   = 0;
      m_done = os ? 1 : 0;
    end else if (!e) begin
      m_tc = 0;
    end else if (term && os) begin
      m_tc   = 1;
      m_done = 1;
    end else begin
      m_tc  = term ? 1 : 0;
      m_cnt = u ? (m_cnt + 1) % (MX + 1) : (m_cnt + MX) % (MX + 1);
    end
    m3_tc = (m3 == 0) ? 1 : 0;
    m3    = (m3 + 7) % 8;
    x.cnt = m_cnt; x.tc = m_tc; x.done = m_done;
    x3.cnt = m3; x3.tc = m3_tc; x3.done = 0;
    q.push_back(x);
    q3.push_back(x3);
  endtask

  // Asynchronous reset between edges; outputs must react without a clock.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_count", count_out, MX);
    chk("rst_tc", tc, 0);
    chk("rst_done", done, 0);
    chk("rst_count3", count3, 7);
    chk("rst_tc3", tc3, 0);
    m_cnt = MX; m_tc = 0; m_done = 0;
    m3 = 7; m3_tc = 0;
  endtask

  // Monitor: pops one expectation per edge that stimulus predicted.
  initial begin
    exp_t e, e3;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        e3 = q3.pop_front();
        chk("count", count_out, e.cnt);
        chk("tc", tc, e.tc);
        chk("done", done, e.done);
        chk("range", (count_out <= MX) ? 1 : 0, 1);
        chk("count3", count3, e3.cnt);
        chk("tc3", tc3, e3.tc);
        chk("done3", done3, e3.done);
      end
    end
  end

  initial begin
    do_reset();
    repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 4'd0);
    repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef UPDN_CNT_LOAD_EN
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    repeat (4) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
`endif
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
           4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, minimum 2.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal (modulus-1) value, legal range 1..2**WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: count enable; count changes only when en=1 or on load.
REQ-006 SHALL have port up_dn, input, 1 bit: direction, 1=up, 0=down, sampled every enabled cycle.
REQ-007 SHALL have port oneshot, input, 1 bit: mode, 1=stop at terminal, 0=auto-reload.
REQ-008 SHALL have port load, input, 1 bit: synchronous parallel load strobe (present only with UPDN_CNT_LOAD_EN).
REQ-009 SHALL have port load_val, input, WIDTH bits: load value (present only with UPDN_CNT_LOAD_EN).
REQ-010 SHALL have port count_out, output, WIDTH bits: registered count value.
REQ-011 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-012 SHALL have port done, output, 1 bit: registered sticky flag, 1 while halted in one-shot mode.

Function
REQ-013 SHALL implement a two-state FSM: RUN (counting) and HALT (one-shot complete, count frozen).
REQ-014 Terminal SHALL be count_out==MAX when up_dn=1, and count_out==0 when up_dn=0.
REQ-015 In RUN with en=1 and not terminal, count_out SHALL step +1 (up) or -1 (down) per cycle. tc SHALL be 0.
REQ-016 In RUN with en=1 at terminal and oneshot=0, count_out SHALL wrap to 0 (up) or MAX (down). tc SHALL be 1 for exactly that next cycle.
REQ-017 In RUN with en=1 at terminal and oneshot=1, count_out SHALL hold. tc SHALL be 1 for one cycle. The FSM SHALL go to HALT, and done SHALL become 1 on the same edge.
REQ-018 In HALT, count_out SHALL hold regardless of en or up_dn. tc SHALL be 0. done SHALL stay 1.
REQ-019 In HALT with oneshot=0, the FSM SHALL return to RUN on the next edge with done cleared, count unchanged.
REQ-020 With en=0 in RUN, count_out SHALL hold and tc SHALL be 0.
REQ-021 load=1 SHALL take priority over en, mode and FSM state. It SHALL write load_val to count_out, clear done and tc, and force RUN.
REQ-022 A load_val greater than MAX SHALL saturate to MAX.
REQ-023 A direction change SHALL take effect on the next enabled edge with no extra latency. The terminal check SHALL use the current up_dn.
REQ-024 Counts SHALL never leave 0..MAX, including when MAX < 2**WIDTH-1.
REQ-025 With WIDTH=3, up_dn=0, oneshot=0 and en tied 1, behaviour SHALL be the legacy down counter: 7..0, wrap to 7, tc pulse concurrent with the wrap.

Reset
REQ-026 rstn=0 SHALL asynchronously force count_out=MAX, tc=0, done=0 and FSM=RUN.
REQ-027 Reset asserted mid-count or in HALT SHALL abandon all state. The first enabled edge after release SHALL count from MAX.

Configuration
REQ-028 Macro UPDN_CNT_LOAD_EN defined: load and load_val ports SHALL exist with REQ-021 and REQ-022 behaviour.
REQ-029 Macro UPDN_CNT_LOAD_EN undefined: load and load_val SHALL be absent. The only ways to leave HALT SHALL be reset and REQ-019. All other behaviour SHALL be identical.

Verification
REQ-030 WIDTH=3, MAX=7, down, auto, en=1 for 9 cycles from reset -> count 6,5,4,3,2,1,0,7,6. tc=1 only at the 7 after 0.
REQ-031 WIDTH=4, MAX=9, up, auto, count 8 -> 9 -> 0 with tc=1 at 0. count_out never exceeds 9.
REQ-032 WIDTH=4, MAX=9, down, oneshot=1, load 2 -> 1, 0, 0 held. tc pulse once. done=1 held. Clearing oneshot -> done=0 next edge.
REQ-033 UPDN_CNT_LOAD_EN, MAX=9: load 13 with en=1 -> count_out=9. Load during HALT -> done=0, RUN resumes.
REQ-034 Count at 5 up, then flip up_dn=0 -> 6, then 5, 4. Toggling en=0 holds the value with tc=0.
REQ-035 rstn pulsed low asynchronously mid-count at 3 -> count_out=MAX immediately, tc=0, done=0.
